// File: rtl/bsg_gray_arb_pkg.sv
// Shared types and helpers for the round-robin gray-to-binary arbiter.
package bsg_gray_arb_pkg;

    // Index width that stays at least one bit wide for a single requester.
    function automatic int unsigned safe_clog2(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Last-grant pointer value after reset, so requester 0 is searched first.
    function automatic int unsigned rr_reset_ptr(input int unsigned els);
        return (els == 0) ? 0 : els - 1;
    endfunction

    localparam int unsigned default_width_lp  = 16;
    localparam int unsigned default_els_lp    = 4;
    localparam int unsigned default_lg_els_lp = 2;

    // Held result layout for the default configuration; the arbiter declares
    // the same layout at its own parameterised widths.
    typedef struct packed {
        logic                         v;
        logic [default_lg_els_lp-1:0] id;
        logic [default_width_lp-1:0]  binary;
    } gray_arb_result_t;

endpackage

// File: rtl/bsg_gray_rr_pick.sv
// Round-robin picker: rotate requests to start after the last grant,
// priority-encode the lowest set bit, then rotate the index back.
module bsg_gray_rr_pick
    import bsg_gray_arb_pkg::*;
#(
    parameter int unsigned  els_p     = 4,
    localparam int unsigned lg_els_lp = safe_clog2(els_p)
) (
    input  logic [els_p-1:0]     req_i,
    input  logic [lg_els_lp-1:0] last_i,
    input  logic                 en_i,
    output logic [els_p-1:0]     grant_o,
    output logic [lg_els_lp-1:0] idx_o,
    output logic                 v_o
);

    int unsigned      start_c;
    int unsigned      off_c;
    int unsigned      sel_c;
    logic             found_c;
    logic [els_p-1:0] rot_c;

    // Rotate, priority encode, rotate back; grant only when enabled.
    always_comb begin
        start_c = (32'(last_i) + 32'd1) % els_p;
        rot_c   = '0;
        for (int unsigned j = 0; j < els_p; j++) begin
            rot_c[j] = req_i[(start_c + j) % els_p];
        end

        found_c = 1'b0;
        off_c   = 0;
        for (int unsigned j = 0; j < els_p; j++) begin
            if (!found_c && rot_c[j]) begin
                found_c = 1'b1;
                off_c   = j;
            end
        end

        sel_c   = (start_c + off_c) % els_p;
        idx_o   = lg_els_lp'(sel_c);
        v_o     = found_c & en_i;
        grant_o = v_o ? (els_p'(1) << sel_c) : '0;
    end

endmodule

// File: rtl/bsg_gray_to_binary.sv
// Combinational gray-code to binary converter.
module bsg_gray_to_binary #(
    parameter int unsigned width_p = 16
) (
    input  logic [width_p-1:0] gray_i,
    output logic [width_p-1:0] binary_o
);

    // Each binary bit is the XOR of all gray bits at or above its position.
    always_comb begin
        binary_o = '0;
        for (int unsigned k = 0; k < width_p; k++) begin
            binary_o[k] = ^(gray_i >> k);
        end
    end

endmodule

// File: rtl/bsg_gray_to_binary_rr_arb.sv
// Time-shares one gray-to-binary converter among els_p requesters with a
// round-robin grant and a one-entry registered, id-tagged result.
module bsg_gray_to_binary_rr_arb
    import bsg_gray_arb_pkg::*;
#(
    parameter int unsigned  width_p   = 16,
    parameter int unsigned  els_p     = 4,
    localparam int unsigned lg_els_lp = safe_clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [els_p-1:0]         v_i,
    input  logic [els_p*width_p-1:0] gray_i,
    output logic [els_p-1:0]         yumi_o,
    output logic                     v_o,
    output logic [width_p-1:0]       binary_o,
    output logic [lg_els_lp-1:0]     id_o,
    input  logic                     yumi_i
);

    typedef struct packed {
        logic                 v;
        logic [lg_els_lp-1:0] id;
        logic [width_p-1:0]   binary;
    } result_t;

    result_t              res_q, res_d;
    logic [lg_els_lp-1:0] last_q, last_d;

    logic                 en_c;
    logic                 accept_c;
    logic [els_p-1:0]     grant_c;
    logic [lg_els_lp-1:0] pick_id_c;
    logic [width_p-1:0]   gray_sel_c;
    logic [width_p-1:0]   binary_c;

    // The output slot can take a new word when empty or being drained;
    // no grant is ever issued while reset is held.
    assign en_c = (~res_q.v | yumi_i) & reset_n_i;

    bsg_gray_rr_pick #(
        .els_p (els_p)
    ) u_pick (
        .req_i   (v_i),
        .last_i  (last_q),
        .en_i    (en_c),
        .grant_o (grant_c),
        .idx_o   (pick_id_c),
        .v_o     (accept_c)
    );

    // One-hot mux of the granted word; unrequested words never reach the converter.
    always_comb begin
        gray_sel_c = '0;
        for (int unsigned i = 0; i < els_p; i++) begin
            if (grant_c[i]) begin
                gray_sel_c = gray_i[i*width_p +: width_p];
            end
        end
    end

    bsg_gray_to_binary #(
        .width_p (width_p)
    ) u_g2b (
        .gray_i   (gray_sel_c),
        .binary_o (binary_c)
    );

    // Next state: load on accept (replacing any drained result), else drain on yumi.
    always_comb begin
        res_d  = res_q;
        last_d = last_q;
        if (accept_c) begin
            res_d.v      = 1'b1;
            res_d.id     = pick_id_c;
            res_d.binary = binary_c;
            last_d       = pick_id_c;
        end else if (yumi_i) begin
            res_d.v = 1'b0;
        end
    end

    // Result register and last-grant pointer.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            res_q  <= '0;
            last_q <= lg_els_lp'(rr_reset_ptr(els_p));
        end else begin
            res_q  <= res_d;
            last_q <= last_d;
        end
    end

    assign yumi_o   = grant_c;
    assign v_o      = res_q.v;
    assign binary_o = res_q.binary;
    assign id_o     = res_q.id;

    // The consumer may only take a result that is actually held.
    yumi_without_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(yumi_i && !res_q.v))
        else $error("yumi_i asserted while v_o is low");

endmodule
